// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART transmitter and the bits receiver:
//   FSM state encodings, the default data width, and a width helper for
//   counters that must be at least one bit wide.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SEND  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } uart_state_e;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Small synchronous FIFO between the producer and the transmit FSM.
//   The head word is presented combinationally on rdata so the FSM can
//   load it in the same cycle it pops.
//   Ports:
//     clk, reset      - clock, synchronous active-high reset (flushes)
//     push, wdata     - write request and data (ignored when full)
//     pop             - read request (ignored when empty)
//     rdata           - current head word
//     full, empty     - occupancy flags
//     count           - number of stored words (0..FIFO_DEPTH)
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_BITS-1:0]          wdata,
  output logic [DATA_BITS-1:0]          rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers are exactly log2(depth) wide, so they wrap modulo the depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_bits_tx.sv
// uart_bits_tx
//   UART transmitter: start bit, DATA_BITS data bits LSB first, stop bit,
//   then IDLE_BITS idle bit times. Words are queued in uart_tx_fifo.
//   Ports:
//     clk       - system clock, rising edge
//     reset     - synchronous active-high reset
//     tx_data   - word to send, sampled on accept
//     tx_valid  - producer offers tx_data
//     tx_ready  - FIFO not full
//     tx        - registered serial line, idle high
//     busy      - frame in progress (including last gap bit) or words queued
//     done      - one-cycle pulse in the last cycle of each stop bit on tx
module uart_bits_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int CLKS_PER_BIT = 1,
  parameter int IDLE_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int TMR_W = clog2_min1(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int GAP_W = clog2_min1(IDLE_BITS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 line_busy_q;
  logic                 bit_tick;

  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  uart_tx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid),
    .pop   (fifo_pop),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_tick = (timer_q == TMR_LAST);

  always_comb begin
    state_d   = state_q;
    timer_d   = bit_tick ? '0 : timer_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rdata;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_tick) state_d = ST_SEND;
      end
      ST_SEND: begin
        tx_d = shift_q[0];
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) state_d = ST_STOP;
          else                       bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          done_d  = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (bit_tick) begin
          if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
          else                       gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // tx and done are registered from the current state, so the line lags
  // the FSM by one cycle and done lines up with the stop bit on tx.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      line_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      line_busy_q <= (state_q != ST_IDLE);
    end
  end

  assign tx       = tx_q;
  assign done     = done_q;
  assign tx_ready = !fifo_full;
  // line_busy_q keeps busy high through the final gap bit still on the line.
  assign busy     = (state_q != ST_IDLE) || line_busy_q || (fifo_count != '0);

endmodule
